// File: rtl/fifo_burst_writer.sv
// Purpose : turns one accepted burst request into a run of incrementing FIFO writes.
// Latency : first write strobe in the cycle after acceptance; one DONE cycle between bursts.
// Backpressure: wfull stalls the write strobe combinationally and freezes all burst state.
//
// Optional feature macro: BURST_CHECKSUM_EN
//   defined   -> one XOR checksum byte is appended after the payload (req_len+1 writes)
//   undefined -> the checksum state and register are absent (exactly req_len writes)
//
// Ports:
//   wclk, wrst_n          write-domain clock, synchronous active-low reset
//   req_valid/req_ready   burst request handshake (ready only while idle)
//   req_len, req_start    payload byte count and first payload value, sampled at acceptance
//   wdata, winc, wfull    FIFO write port; wfull is already synchronised to wclk
//   w_burst_id            count of accepted bursts (current or most recent)
//   busy                  high whenever the block is not idle
//   burst_done            one-cycle pulse when a burst completes
module fifo_burst_writer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_start,
    output logic [DATA_W-1:0] wdata,
    output logic              winc,
    input  logic              wfull,
    output logic [31:0]       w_burst_id,
    output logic              busy,
    output logic              burst_done
);

`ifdef BURST_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CSUM  = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              last_beat;
`ifdef BURST_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // Handshake and strobe outputs are gated by reset so nothing leaks out while
    // wrst_n is low, even before the state register has been cleared.
    assign req_ready = wrst_n && (state == IDLE);
    assign busy      = wrst_n && (state != IDLE);
    assign accept    = req_valid && req_ready;
`ifdef BURST_CHECKSUM_EN
    assign winc      = wrst_n && !wfull && ((state == WRITE) || (state == CSUM));
`else
    assign winc      = wrst_n && !wfull && (state == WRITE);
`endif
    assign last_beat = (remaining == LEN_W'(1));
    assign wdata     = wdata_q;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_len != '0) begin
                        state_nxt = WRITE;
                    end else begin
`ifdef BURST_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
            WRITE: begin
                if (winc && last_beat) begin
`ifdef BURST_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef BURST_CHECKSUM_EN
            CSUM: begin
                if (winc) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // burst_done is registered from the next state so it is high exactly for the DONE cycle.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            burst_done <= 1'b0;
        end else begin
            burst_done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            w_burst_id <= '0;
        end else if (accept) begin
            w_burst_id <= w_burst_id + 32'd1;
        end
    end

    // Datapath. Nothing moves unless a request is accepted or a WRITE beat is
    // actually strobed, so a wfull stall holds wdata/remaining/csum for free.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            remaining <= '0;
            wdata_q   <= '0;
`ifdef BURST_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (accept) begin
            remaining <= req_len;
`ifdef BURST_CHECKSUM_EN
            csum      <= '0;
            // An empty burst goes straight to CSUM, whose data is the (zero) checksum.
            wdata_q   <= (req_len == '0) ? '0 : req_start;
`else
            wdata_q   <= req_start;
`endif
        end else if ((state == WRITE) && winc) begin
            remaining <= remaining - LEN_W'(1);
`ifdef BURST_CHECKSUM_EN
            csum      <= csum ^ wdata_q;
            // On the final payload beat present the completed checksum for CSUM.
            wdata_q   <= last_beat ? (csum ^ wdata_q) : (wdata_q + DATA_W'(1));
`else
            wdata_q   <= wdata_q + DATA_W'(1);
`endif
        end
    end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 Parameter: DATA_W, default 8, FIFO write-data width.
REQ-002 Parameter: LEN_W, default 8, width of the burst-length field.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port: wclk  in  1  write-domain clock; all state updates on its rising edge.
REQ-005 Port: wrst_n  in  1  synchronous active-low reset.
REQ-006 Port: req_valid  in  1  burst request present.
REQ-007 Port: req_ready  out  1  block can accept a request this cycle.
REQ-008 Port: req_len  in  LEN_W  payload byte count; 0 is legal.
REQ-009 Port: req_start  in  DATA_W  first payload value.
REQ-010 Port: wdata  out  DATA_W  FIFO write data.
REQ-011 Port: winc  out  1  FIFO write strobe.
REQ-012 Port: wfull  in  1  FIFO full flag, already synchronised to wclk.
REQ-013 Port: w_burst_id  out  32  ID of the current or most recent burst.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: burst_done  out  1  one-cycle pulse at burst completion.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, CSUM and DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur when req_valid && req_ready at the clock edge.
REQ-018 On acceptance the block SHALL load remaining=req_len, wdata=req_start and csum=0, and set w_burst_id=w_burst_id+1 (mod 2^32).
REQ-019 After acceptance the next state SHALL be WRITE if req_len!=0, otherwise CSUM if BURST_CHECKSUM_EN is defined, otherwise DONE.
REQ-020 winc SHALL equal (state==WRITE || state==CSUM) && !wfull, combinationally on wfull; winc SHALL never be high while wfull=1.
REQ-021 For each WRITE beat with winc=1, the block SHALL do remaining-1, csum^=wdata, wdata=wdata+1 (wrap modulo 2^DATA_W, e.g. 0xFF -> 0x00).
REQ-022 When winc=1 and remaining==1 in WRITE, the next state SHALL be CSUM if the macro is defined, else DONE.
REQ-023 On entry to CSUM, wdata SHALL hold the final csum; after one winc=1 beat the next state SHALL be DONE.
REQ-024 While wfull=1, wdata, remaining and csum SHALL hold, with no beat lost or duplicated.
REQ-025 DONE SHALL last exactly one cycle with burst_done=1, then go to IDLE.
REQ-026 Latency: acceptance at edge N SHALL make the first possible winc in cycle N+1; the minimum gap between bursts is one cycle (the DONE state).
REQ-027 req_valid outside IDLE SHALL be ignored, with no queueing.
REQ-028 req_len and req_start SHALL be sampled only at acceptance; later changes have no effect.
REQ-029 wdata SHALL hold its last value in IDLE and DONE.

Reset
REQ-030 When wrst_n=0 at an edge, the block SHALL set state=IDLE, wdata=0, remaining=0, csum=0, w_burst_id=0 and burst_done=0.
REQ-031 During reset winc SHALL be 0, busy 0 and req_ready 0; req_ready SHALL be 1 in the first cycle after reset is released.
REQ-032 Reset mid-burst SHALL abandon the burst: no further winc and no burst_done pulse.

Configuration
REQ-033 Macro BURST_CHECKSUM_EN defined: the CSUM state SHALL exist and append one byte (XOR of all payload bytes, 0x00 for req_len=0), giving req_len+1 writes per burst.
REQ-034 Macro BURST_CHECKSUM_EN undefined: CSUM SHALL be unreachable and removed, and each burst SHALL be exactly req_len writes.

Verification
REQ-035 Reset, then len=4, start=0x10, wfull=0 -> winc high for 4 consecutive cycles starting the cycle after acceptance, wdata 10,11,12,13; with the macro defined, a 5th beat of 0x00; then burst_done; w_burst_id=1.
REQ-036 len=3, start=0xFE -> wdata FE,FF,00; with the macro defined, csum=0x01.
REQ-037 len=5, with wfull forced high for 3 cycles after the 2nd beat -> winc low during those cycles, wdata held, all 5 values delivered in order with none lost or repeated.
REQ-038 len=0 -> no payload beats; with the macro, one beat of 0x00; burst_done pulses; w_burst_id increments.
REQ-039 wrst_n low after 2 of 6 beats -> winc 0 from the next cycle, no burst_done, w_burst_id=0, req_ready=1 after release.
REQ-040 Second req_valid held during a busy burst -> ignored until IDLE, then accepted one cycle after burst_done, and w_burst_id=2.
